elevator_scheduler: RTL

Request scheduler and motion sequencer for a multi-floor elevator car. It latches floor call buttons and chooses a travel direction with LOOK ordering: keep going while calls lie ahead, otherwise reverse. It steps the car one floor at a time on a fixed travel timer and holds the door open for a fixed dwell at each serviced floor. It sits above the one-hot floor-state logic, drives the car position, and exposes the pending-call vector for lamps and debug.

---
 rtl/elevator_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//   LOOK-ordered request scheduler and motion sequencer for one elevator car.
//   Floor calls are latched into a pending mask. While idle, the car serves
//   its own floor first. Otherwise it keeps its current heading if calls lie
//   ahead, and reverses only when nothing is ahead. The car steps one floor
//   every MOVE_CYC cycles and holds the door for DOOR_CYC cycles at each stop.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   req        floor call buttons (bitmask, bit 0 = floor 1), pulse or level
//   floor      one-hot current car floor
//   pending    latched, not yet serviced calls
//   dir_up     1 = travelling/preferring up, 0 = down
//   moving     high while the car is travelling between floors
//   door_open  high while the door dwell is running
//   arrive     one-cycle pulse coincident with a new floor value
module elevator_scheduler #(
    parameter int NFLR     = 5,
    parameter int MOVE_CYC = 4,
    parameter int DOOR_CYC = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NFLR-1:0] req,
    output logic [NFLR-1:0] floor,
    output logic [NFLR-1:0] pending,
    output logic            dir_up,
    output logic            moving,
    output logic            door_open,
    output logic            arrive
);

    localparam int MC_W = $clog2(MOVE_CYC);
    localparam int DC_W = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
    localparam logic [NFLR-1:0] FLOOR1 = NFLR'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NFLR-1:0] floor_q, floor_d;
    logic [NFLR-1:0] pending_q, pending_d;
    logic            dir_up_q, dir_up_d;
    logic [MC_W-1:0] mcnt_q, mcnt_d;
    logic [DC_W-1:0] dcnt_q, dcnt_d;
    logic            arrive_q, arrive_d;

    logic [NFLR-1:0] calls;
    logic [NFLR-1:0] lower_mask;
    logic [NFLR-1:0] step_floor;
    logic [NFLR-1:0] clr;
    logic            here;
    logic            above;
    logic            below;

    // Requests are considered together with latched calls so that a button
    // pressed on the deciding edge is honoured without a cycle of latency.
    // floor_q is one-hot, so floor_q - 1 masks every floor below the car.
    assign calls      = pending_q | req;
    assign lower_mask = floor_q - FLOOR1;
    assign here       = |(calls & floor_q);
    assign below      = |(calls & lower_mask);
    assign above      = |(calls & ~(lower_mask | floor_q));
    assign step_floor = dir_up_q ? {floor_q[NFLR-2:0], 1'b0}
                                 : {1'b0, floor_q[NFLR-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            floor_q   <= FLOOR1;
            pending_q <= '0;
            dir_up_q  <= 1'b1;
            mcnt_q    <= '0;
            dcnt_q    <= '0;
            arrive_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            dir_up_q  <= dir_up_d;
            mcnt_q    <= mcnt_d;
            dcnt_q    <= dcnt_d;
            arrive_q  <= arrive_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        mcnt_d   = mcnt_q;
        dcnt_d   = dcnt_q;
        arrive_d = 1'b0;
        clr      = '0;
        case (state_q)
            S_IDLE: begin
                if (here) begin
                    state_d = S_DOOR;
                    clr     = floor_q;
                    dcnt_d  = '0;
                end else if (above && (dir_up_q || !below)) begin
                    dir_up_d = 1'b1;
                    state_d  = S_MOVE;
                    mcnt_d   = '0;
                end else if (below) begin
                    dir_up_d = 1'b0;
                    state_d  = S_MOVE;
                    mcnt_d   = '0;
                end
            end
            S_MOVE: begin
                if (mcnt_q == MC_W'(MOVE_CYC - 1)) begin
                    // A step is taken only while a call lies ahead, so the
                    // shifted floor can never fall off either end.
                    floor_d  = step_floor;
                    arrive_d = 1'b1;
                    mcnt_d   = '0;
                    if (|(calls & step_floor)) begin
                        state_d = S_DOOR;
                        clr     = step_floor;
                        dcnt_d  = '0;
                    end
                end else begin
                    mcnt_d = mcnt_q + 1'b1;
                end
            end
            S_DOOR: begin
                // A call at the open floor extends the dwell instead of
                // being latched as a new request.
                if (|(req & floor_q)) begin
                    clr    = floor_q;
                    dcnt_d = '0;
                end else if (dcnt_q == DC_W'(DOOR_CYC - 1)) begin
                    state_d = S_IDLE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        pending_d = calls & ~clr;
    end

    always_comb begin
        moving    = (state_q == S_MOVE);
        door_open = (state_q == S_DOOR);
        floor     = floor_q;
        pending   = pending_q;
        dir_up    = dir_up_q;
        arrive    = arrive_q;
    end

endmodule
